// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall / flush / forward controller for the 5-stage RISC-V pipe.
//   All control outputs are Mealy (combinational from state + inputs) so a
//   hazard takes effect in the cycle it is seen; only the FSM state, the
//   memory-wait counter, the sticky error flag and the perf counters are
//   registered.
//
//   Optional feature macro: PIPE_HAZARD_PERF_EN
//     defined   -> stall_cnt / flush_cnt saturating perf counters are built
//     undefined -> both counter outputs are tied to 16'h0000
//
// Ports
//   clk, rst                    clock (rising edge), sync active-high reset
//   id_rs1/2, id_use_rs1/2      ID-stage source regs and their use flags
//   ex_rs1/2, ex_rd             EX-stage source / destination regs
//   ex_reg_wen, ex_mem_read     EX instruction writes RF / is a load
//   ex_branch_taken             taken branch/jump resolved in EX
//   mem_rd, mem_reg_wen         MEM-stage destination / RF write
//   mem_req, mem_ready          data-memory access in flight / completed
//   wb_rd, wb_reg_wen           WB-stage destination / RF write
//   pc_en .. mem_wb_en          stage capture enables
//   if_id_flush, id_ex_flush    load a bubble on next capture
//   mem_wb_bubble               MEM_WB captures RegWEn=0
//   fwd_a, fwd_b                00 RF, 01 EX/MEM, 10 MEM/WB
//   mem_timeout_err             sticky memory-timeout flag
//   stall_cnt, flush_cnt        performance counters
// ---------------------------------------------------------------------------

// Per-operand forwarding select. One instance per EX source operand.
module pipe_fwd_sel #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_wen,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_wen,
  output logic [1:0]        fwd
);
  always_comb begin
    fwd = 2'b00;
    // EX/MEM is the younger producer, so it wins over MEM/WB.
    if (mem_reg_wen && (mem_rd != '0) && (mem_rd == ex_rs))
      fwd = 2'b01;
    else if (wb_reg_wen && (wb_rd != '0) && (wb_rd == ex_rs))
      fwd = 2'b10;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_wen,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_wen,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_wen,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              mem_wb_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_timeout_err,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  localparam int         NUM_OPS = 2;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERR} state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       err_q, err_nxt;

  logic       load_use;
  logic       mem_stall;
  logic       run_rules;

  // -------------------------------------------------------------------------
  // Forwarding: one selector per EX operand
  // -------------------------------------------------------------------------
  logic [NUM_OPS-1:0][REG_AW-1:0] ex_rs;
  logic [NUM_OPS-1:0][1:0]        fwd_sel;

  assign ex_rs = {ex_rs2, ex_rs1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
      .ex_rs       (ex_rs[g]),
      .mem_rd      (mem_rd),
      .mem_reg_wen (mem_reg_wen),
      .wb_rd       (wb_rd),
      .wb_reg_wen  (wb_reg_wen),
      .fwd         (fwd_sel[g])
    );
  end

  assign fwd_a = rst ? 2'b00 : fwd_sel[0];
  assign fwd_b = rst ? 2'b00 : fwd_sel[1];

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  assign load_use = ex_mem_read && ex_reg_wen && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign mem_stall = mem_req && !mem_ready;

  // -------------------------------------------------------------------------
  // FSM next-state and Mealy outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    err_nxt       = err_q;
    run_rules     = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;

    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
      state_nxt     = S_RUN;
      wait_cnt_nxt  = 8'd0;
      err_nxt       = 1'b0;
    end else begin
      unique case (state)
        S_RUN: begin
          if (mem_stall) begin
            state_nxt    = S_MEM_WAIT;
            wait_cnt_nxt = 8'd1;
          end else begin
            run_rules = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            state_nxt    = S_RUN;
            wait_cnt_nxt = 8'd0;
            run_rules    = 1'b1;
          end else if (wait_cnt == TIMEOUT) begin
            state_nxt = S_ERR;
            err_nxt   = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
        end
        S_ERR: begin
          err_nxt = 1'b1;
        end
        default: begin
          state_nxt = S_RUN;
        end
      endcase

      if (run_rules) begin
        if (ex_branch_taken) begin
          // ID instruction is discarded, so any load-use on it is moot.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end else if (state == S_ERR) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else begin
        // Memory hold: freeze everything up to EX/MEM and drain a bubble
        // into MEM/WB so WB does not re-commit the stalled instruction.
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  assign mem_timeout_err = err_q;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
    end else begin
      if (!pc_en && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'h0001;
      if (id_ex_flush && (flush_q != 16'hFFFF))
        flush_q <= flush_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4. Each step drives
//   inputs, then compares the Mealy control vector, forwarding selects, the
//   error flag and the perf counters against hand-derived values.
//   Control vector order: {pc,if_id,id_ex,ex_mem,mem_wb,if_flush,id_flush,bub}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;

  localparam logic [7:0] C_RST  = 8'b00000_111;
  localparam logic [7:0] C_RUN  = 8'b11111_000;
  localparam logic [7:0] C_LU   = 8'b00111_010;
  localparam logic [7:0] C_BR   = 8'b11111_110;
  localparam logic [7:0] C_HOLD = 8'b00001_001;
  localparam logic [7:0] C_ERR  = 8'b00000_001;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_reg_wen, ex_mem_read, ex_branch_taken;
  logic          mem_reg_wen, mem_req, mem_ready, wb_reg_wen;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [15:0]   stall_cnt, flush_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  last_ctl = C_RST;
  logic [15:0] exp_stall = 16'h0;
  logic [15:0] exp_flush = 16'h0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_wen(mem_reg_wen), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_reg_wen = 0; ex_mem_read = 0;
    ex_branch_taken = 0; mem_rd = '0; mem_reg_wen = 0; mem_req = 0; mem_ready = 0;
    wb_rd = '0; wb_reg_wen = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] ec, input logic [1:0] ea,
                     input logic [1:0] eb, input logic ee);
    logic [7:0] oc;
    #1;
    oc = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
          if_id_flush, id_ex_flush, mem_wb_bubble};
    tests++;
    assert (oc === ec) else begin
      fails++; $error("FAIL %s ctl got=%b want=%b", tag, oc, ec);
    end
    tests++;
    assert (fwd_a === ea) else begin
      fails++; $error("FAIL %s fwd_a got=%b want=%b", tag, fwd_a, ea);
    end
    tests++;
    assert (fwd_b === eb) else begin
      fails++; $error("FAIL %s fwd_b got=%b want=%b", tag, fwd_b, eb);
    end
    tests++;
    assert (mem_timeout_err === ee) else begin
      fails++; $error("FAIL %s err got=%b want=%b", tag, mem_timeout_err, ee);
    end
    tests++;
    assert (stall_cnt === exp_stall) else begin
      fails++; $error("FAIL %s stall_cnt got=%0d want=%0d", tag, stall_cnt, exp_stall);
    end
    tests++;
    assert (flush_cnt === exp_flush) else begin
      fails++; $error("FAIL %s flush_cnt got=%0d want=%0d", tag, flush_cnt, exp_flush);
    end
    last_ctl = ec;
  endtask

  // Advance one clock; the expected counters follow the control vector that
  // was required during the cycle just ending.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_stall = 16'h0;
      exp_flush = 16'h0;
    end else begin
`ifdef PIPE_HAZARD_PERF_EN
      if (!last_ctl[7] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'h1;
      if (last_ctl[1]  && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'h1;
`endif
    end
    #1;
  endtask

  initial begin
    rst = 1; clr();
    @(posedge clk); #1;
    chk("rst_c1", C_RST, 2'b00, 2'b00, 1'b0); tick();
    chk("rst_c2", C_RST, 2'b00, 2'b00, 1'b0); tick();
    rst = 0;
    chk("run_idle", C_RUN, 2'b00, 2'b00, 1'b0); tick();

    // Load-use on rs2, one cycle, then the load has moved on
    ex_mem_read = 1; ex_reg_wen = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    chk("lu_rs2", C_LU, 2'b00, 2'b00, 1'b0); tick();
    ex_mem_read = 0; ex_reg_wen = 0;
    chk("lu_clear", C_RUN, 2'b00, 2'b00, 1'b0); tick();
    // x0 destination never stalls
    ex_mem_read = 1; ex_reg_wen = 1; ex_rd = 0; id_rs2 = 0;
    chk("lu_x0", C_RUN, 2'b00, 2'b00, 1'b0); tick();
    // rs1 match, then same regs without the use flag
    ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1; id_use_rs2 = 0;
    chk("lu_rs1", C_LU, 2'b00, 2'b00, 1'b0); tick();
    id_use_rs1 = 0;
    chk("lu_nouse", C_RUN, 2'b00, 2'b00, 1'b0); tick();
    // Branch beats load-use
    id_use_rs1 = 1; ex_branch_taken = 1;
    chk("br_over_lu", C_BR, 2'b00, 2'b00, 1'b0); tick();
    clr();

    // Memory wait: three hold cycles then release
    mem_req = 1; mem_ready = 0;
    chk("mw_hold1", C_HOLD, 2'b00, 2'b00, 1'b0); tick();
    chk("mw_hold2", C_HOLD, 2'b00, 2'b00, 1'b0); tick();
    chk("mw_hold3", C_HOLD, 2'b00, 2'b00, 1'b0); tick();
    mem_ready = 1;
    chk("mw_release", C_RUN, 2'b00, 2'b00, 1'b0); tick();
    mem_req = 0; mem_ready = 0;
    chk("mw_back_run", C_RUN, 2'b00, 2'b00, 1'b0); tick();

    // Branch ignored while holding, honoured on release
    mem_req = 1; ex_branch_taken = 1;
    chk("mwb_hold1", C_HOLD, 2'b00, 2'b00, 1'b0); tick();
    chk("mwb_hold2", C_HOLD, 2'b00, 2'b00, 1'b0); tick();
    mem_ready = 1;
    chk("mwb_release", C_BR, 2'b00, 2'b00, 1'b0); tick();
    clr();

    // Timeout: RUN stall cycle + MEM_WAIT with wait_cnt 1..4, then ERR
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("to_hold%0d", i), C_HOLD, 2'b00, 2'b00, 1'b0); tick();
    end
    chk("to_err", C_ERR, 2'b00, 2'b00, 1'b1); tick();
    mem_req = 0; mem_ready = 1; ex_branch_taken = 1;
    chk("err_sticky", C_ERR, 2'b00, 2'b00, 1'b1); tick();
    ex_rs1 = 3; mem_rd = 3; mem_reg_wen = 1;
    chk("err_fwd", C_ERR, 2'b01, 2'b00, 1'b1); tick();
    ex_branch_taken = 0; mem_ready = 0;

    // Reset out of ERR: forwarding forced to 00 while rst is high
    rst = 1;
    chk("rst_err_c1", C_RST, 2'b00, 2'b00, 1'b1); tick();
    chk("rst_err_c2", C_RST, 2'b00, 2'b00, 1'b0); tick();
    rst = 0;
    chk("post_rst", C_RUN, 2'b01, 2'b00, 1'b0); tick();

    // Forwarding priority and x0
    wb_rd = 3; wb_reg_wen = 1;
    chk("fa_mem_pri", C_RUN, 2'b01, 2'b00, 1'b0); tick();
    mem_reg_wen = 0;
    chk("fa_wb", C_RUN, 2'b10, 2'b00, 1'b0); tick();
    ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_reg_wen = 1;
    chk("fa_x0", C_RUN, 2'b00, 2'b00, 1'b0); tick();
    ex_rs2 = 9; mem_rd = 9; wb_rd = 9;
    chk("fb_mem", C_RUN, 2'b00, 2'b01, 1'b0); tick();
    mem_rd = 4; ex_rs1 = 4;
    chk("fab_split", C_RUN, 2'b01, 2'b10, 1'b0); tick();
    wb_reg_wen = 0;
    chk("fb_none", C_RUN, 2'b01, 2'b00, 1'b0); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage RISC-V pipeline.
- Drives the capture enables and flush/bubble controls of the IF_ID, ID_EX, EX_MEM and MEM_WB registers and the PC.
- Resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits.
- Generates EX-stage operand forwarding selects.
- Contains a small FSM for memory-wait sequencing and timeout error handling.

Parameters:
- REG_AW, 5, register index width.
- MEM_TIMEOUT, 15, maximum consecutive MEM_WAIT cycles before error (range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2.
- ex_rs1, ex_rs2  in  REG_AW  source registers of the instruction in EX.
- ex_rd  in  REG_AW  destination register in EX.
- ex_reg_wen  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  taken branch/jump resolved in EX.
- mem_rd  in  REG_AW  destination register in MEM.
- mem_reg_wen  in  1  MEM instruction writes the register file.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory has completed the access.
- wb_rd  in  REG_AW  destination register in WB.
- wb_reg_wen  in  1  WB instruction writes the register file.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage capture enables.
- if_id_flush, id_ex_flush  out  1  load a bubble (RegWEn=0, no memory op) on the next capture.
- mem_wb_bubble  out  1  MEM_WB captures RegWEn=0.
- fwd_a, fwd_b  out  2  EX operand select: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- mem_timeout_err  out  1  sticky error flag.
- stall_cnt  out  16  performance counter (see Optional Feature).
- flush_cnt  out  16  performance counter (see Optional Feature).

Behaviour:
- All control outputs are combinational from state and inputs (Mealy), so they take effect in the same cycle.
- Counters, state and err are registered.
- Reset:
  - While rst=1: all *_en=0; if_id_flush=id_ex_flush=mem_wb_bubble=1; fwd=00.
  - Next state is RUN; wait_cnt=0, mem_timeout_err=0, stall_cnt=flush_cnt=0.
  - Reset taken mid-MEM_WAIT or in ERR returns to RUN immediately.
- FSM states: RUN, MEM_WAIT, ERR.
- RUN decision, priority high to low:
  1. Memory stall, mem_req && !mem_ready:
     - pc/if_id/id_ex/ex_mem_en=0, mem_wb_en=1, mem_wb_bubble=1.
     - Go to MEM_WAIT with wait_cnt=1.
  2. Branch, ex_branch_taken:
     - All enables=1, if_id_flush=id_ex_flush=1.
     - Stay in RUN. No load-use stall is applied this cycle, because the ID instruction is discarded.
  3. Load-use, ex_mem_read && ex_reg_wen && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)):
     - pc_en=if_id_en=0, id_ex_en=1, id_ex_flush=1; exactly one cycle.
     - Stay in RUN; the hazard clears as the load advances.
  4. Otherwise all enables=1, no flush.
- MEM_WAIT:
  - mem_ready=1: release. Apply the RUN rules 2–4 in the same cycle; go to RUN; wait_cnt=0.
  - mem_ready=0 and wait_cnt==MEM_TIMEOUT: go to ERR, set mem_timeout_err.
  - Otherwise hold all stages as in rule 1 and increment wait_cnt (8 bits).
  - ex_branch_taken is ignored while holding.
- ERR: all enables=0, mem_wb_bubble=1, mem_timeout_err=1; leave only by reset.
- Forwarding (all states):
  - fwd_a=01 if mem_reg_wen && mem_rd!=0 && mem_rd==ex_rs1.
  - Else fwd_a=10 if wb_reg_wen && wb_rd!=0 && wb_rd==ex_rs1.
  - Else fwd_a=00.
  - fwd_b is computed the same way from ex_rs2.
  - EX/MEM always has priority over MEM/WB.
- Register x0 never triggers a hazard or a forward.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments in every non-reset cycle with pc_en=0.
  - flush_cnt increments in every cycle with id_ex_flush=1 while rst=0.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: counters are not built and both outputs are tied to 16'h0000.

Test Plan:
- Reset: rst=1 for 2 cycles → enables 0, both flushes 1, mem_wb_bubble 1, err 0; first cycle after release with no hazards → all enables 1.
- Load-use stall: ex_mem_read=1, ex_reg_wen=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → one cycle of pc_en=if_id_en=0 and id_ex_flush=1. With PIPE_HAZARD_PERF_EN defined → stall_cnt=1. Repeat with ex_rd=0 → no stall.
- Branch beats load-use: ex_branch_taken=1 together with the load-use condition → all enables 1, if_id_flush=id_ex_flush=1, no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → 3 hold cycles with mem_wb_bubble=1, release on the 4th cycle, back to RUN.
- Timeout: MEM_TIMEOUT=4, mem_ready held at 0 → ERR entered and mem_timeout_err=1, stays set until rst; all enables 0 meanwhile.
- Forwarding: ex_rs1=3, mem_rd=3/mem_reg_wen=1, wb_rd=3/wb_reg_wen=1 → fwd_a=01; drop mem_reg_wen → fwd_a=10; set ex_rs1=0 → fwd_a=00.
